// File: rtl/counter_mux_sel_ctrl_pkg.sv
// Shared types and constants for the counter mux select controller.
// Holds the sequencer state encoding, the default channel count and the counter sizing helper.
package counter_mux_sel_ctrl_pkg;

  localparam int COUNTER_NUM_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Width of the shared drain/settle counter. It only ever holds (cycles - 1), and is never narrower than one bit.
  function automatic int cnt_width(input int drain_cyc, input int settle_cyc);
    int m;
    m = (drain_cyc > settle_cyc) ? drain_cyc : settle_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/counter_mux_sel_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after the one-hot pointer,
// wrapping around to bit 0. The pointer register itself lives in the controller.
module counter_rr_arbiter
  import counter_mux_sel_ctrl_pkg::*;
#(
  parameter int N = COUNTER_NUM_DEF
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] grant,
  output logic         valid
);

  logic [N-1:0] above_mask;
  logic [N-1:0] req_hi;

  // Bits strictly above the pointer. If the pointer is at the top bit, the mask is empty and arbitration wraps.
  assign above_mask = ~((ptr << 1) - N'(1));
  assign req_hi     = req & above_mask;

  // x & -x isolates the lowest set bit.
  always_comb begin
    if (|req_hi) begin
      grant = req_hi & (~req_hi + N'(1));
    end else begin
      grant = req & (~req + N'(1));
    end
  end

  assign valid = |req;

endmodule

// File: rtl/counter_mux_sel_ctrl.sv
// Glitch-safe select sequencer for the per-channel counter data mux. One shared sequencer runs
// gate -> drain -> flip select -> settle -> re-enable -> ack for round-robin granted channels.
module counter_mux_sel_ctrl
  import counter_mux_sel_ctrl_pkg::*;
#(
  parameter int                     COUNTER_NUM = COUNTER_NUM_DEF,
  parameter int                     DRAIN_CYC   = 4,
  parameter int                     SETTLE_CYC  = 4,
  parameter logic [COUNTER_NUM-1:0] SEL_RST     = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [COUNTER_NUM-1:0] i_sel_req,
  input  logic [COUNTER_NUM-1:0] i_sel_target,
  output logic [COUNTER_NUM-1:0] o_mux_sel,
  output logic [COUNTER_NUM-1:0] o_chan_en,
  output logic [COUNTER_NUM-1:0] o_sel_ack,
  output logic                   o_busy
);

  localparam int                     CNT_W       = cnt_width(DRAIN_CYC, SETTLE_CYC);
  localparam logic [CNT_W-1:0]       DRAIN_LOAD  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [COUNTER_NUM-1:0] PTR_RST     = COUNTER_NUM'(1) << (COUNTER_NUM - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [COUNTER_NUM-1:0] ptr;
  logic [COUNTER_NUM-1:0] gnt;
  logic                   tgt;

  logic [COUNTER_NUM-1:0] arb_grant;
  logic                   arb_valid;
  logic                   arb_tgt;
  logic                   arb_cur_sel;

  logic                   take;
  logic                   skip;
  logic                   flip;
  logic                   finish;

  counter_rr_arbiter #(
    .N (COUNTER_NUM)
  ) u_arb (
    .req   (i_sel_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Target and current select of the channel the arbiter would grant this cycle.
  assign arb_tgt     = |(i_sel_target & arb_grant);
  assign arb_cur_sel = |(o_mux_sel & arb_grant);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    skip      = 1'b0;
    flip      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          take = 1'b1;
          if (arb_tgt == arb_cur_sel) begin
            skip = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          flip      = 1'b1;
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant bookkeeping and per-channel outputs. Only the granted channel's bits ever change.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr       <= PTR_RST;
      gnt       <= '0;
      tgt       <= 1'b0;
      o_mux_sel <= SEL_RST;
      o_chan_en <= '1;
      o_sel_ack <= '0;
    end else begin
      o_sel_ack <= '0;
      if (take) begin
        ptr <= arb_grant;
        gnt <= arb_grant;
        tgt <= arb_tgt;
        if (skip) begin
          o_sel_ack <= arb_grant;
        end else begin
          o_chan_en <= o_chan_en & ~arb_grant;
        end
      end
      if (flip) begin
        o_mux_sel <= (o_mux_sel & ~gnt) | (tgt ? gnt : '0);
      end
      if (finish) begin
        o_chan_en <= o_chan_en | gnt;
        o_sel_ack <= gnt;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_counter_mux_sel_ctrl.sv
// Directed bench for counter_mux_sel_ctrl with DRAIN_CYC = SETTLE_CYC = 4 and four channels.
// Cycle 0 is the cycle in which a request is first presented; the grant happens at its closing edge.
module tb_counter_mux_sel_ctrl;

  localparam int N = 4;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic [N-1:0] i_sel_req = '0;
  logic [N-1:0] i_sel_target = '0;
  logic [N-1:0] o_mux_sel;
  logic [N-1:0] o_chan_en;
  logic [N-1:0] o_sel_ack;
  logic         o_busy;

  int tests = 0;
  int fails = 0;

  counter_mux_sel_ctrl #(
    .COUNTER_NUM (N),
    .DRAIN_CYC   (4),
    .SETTLE_CYC  (4),
    .SEL_RST     (4'b0000)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_sel_req    (i_sel_req),
    .i_sel_target (i_sel_target),
    .o_mux_sel    (o_mux_sel),
    .o_chan_en    (o_chan_en),
    .o_sel_ack    (o_sel_ack),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven and outputs sampled there.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_sel_req    = '0;
    i_sel_target = '0;
    i_rstn       = 1'b0;
    step(2);
    i_rstn = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ack_seen;
    logic [N-1:0] exp_en;
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_sel;
    int           k;
    int           ph;

    // 1: reset state, reset in mid-drain, channel 0 wins first afterwards
    do_reset();
    check("rst_sel", 32'(o_mux_sel), 32'h0);
    check("rst_en", 32'(o_chan_en), 32'hF);
    check("rst_ack", 32'(o_sel_ack), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    i_sel_req    = 4'b0100;
    i_sel_target = 4'b0100;
    step(1);
    check("t1_en_gated", 32'(o_chan_en), 32'hB);
    step(1);
    i_rstn = 1'b0;
    #1;
    check("t1_abort_sel", 32'(o_mux_sel), 32'h0);
    check("t1_abort_en", 32'(o_chan_en), 32'hF);
    check("t1_abort_busy", 32'(o_busy), 32'h0);
    i_sel_req = '0;
    step(2);
    i_rstn   = 1'b1;
    ack_seen = '0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      ack_seen = ack_seen | o_sel_ack;
    end
    check("t1_no_ack", 32'(ack_seen), 32'h0);
    i_sel_req    = 4'b1001;
    i_sel_target = 4'b1001;
    step(1);
    check("t1_first_ch0", 32'(o_chan_en), 32'hE);
    step(8);
    check("t1_ack0", 32'(o_sel_ack), 32'h1);
    i_sel_req = 4'b1000;
    step(1);
    check("t1_then_ch3", 32'(o_chan_en), 32'h7);
    step(8);
    check("t1_ack3", 32'(o_sel_ack), 32'h8);
    check("t1_sel", 32'(o_mux_sel), 32'h9);
    i_sel_req = '0;

    // 2: single switch on channel 1
    do_reset();
    i_sel_req    = 4'b0010;
    i_sel_target = 4'b0010;
    check("t2_busy0", 32'(o_busy), 32'h0);
    for (int c = 1; c <= 9; c++) begin
      step(1);
      exp_en  = (c <= 8) ? 4'b1101 : 4'b1111;
      exp_sel = (c >= 5) ? 4'b0010 : 4'b0000;
      exp_ack = (c == 9) ? 4'b0010 : 4'b0000;
      check($sformatf("t2_en_c%0d", c), 32'(o_chan_en), 32'(exp_en));
      check($sformatf("t2_sel_c%0d", c), 32'(o_mux_sel), 32'(exp_sel));
      check($sformatf("t2_ack_c%0d", c), 32'(o_sel_ack), 32'(exp_ack));
      check($sformatf("t2_busy_c%0d", c), 32'(o_busy), (c <= 8) ? 32'h1 : 32'h0);
      if (c == 9) i_sel_req = '0;
    end
    step(1);
    check("t2_ack_pulse_end", 32'(o_sel_ack), 32'h0);

    // 3: skip path, target already selected
    do_reset();
    i_sel_req    = 4'b1000;
    i_sel_target = 4'b0000;
    step(1);
    check("t3_ack", 32'(o_sel_ack), 32'h8);
    check("t3_en", 32'(o_chan_en), 32'hF);
    check("t3_busy", 32'(o_busy), 32'h0);
    i_sel_req = '0;
    step(1);
    check("t3_ack_end", 32'(o_sel_ack), 32'h0);
    check("t3_en_end", 32'(o_chan_en), 32'hF);

    // 4: all four channels request together
    do_reset();
    i_sel_req    = 4'b1111;
    i_sel_target = 4'b1111;
    for (int c = 1; c <= 36; c++) begin
      step(1);
      k       = (c - 1) / 9;
      ph      = (c - 1) % 9 + 1;
      exp_en  = (ph <= 8) ? (4'b1111 & ~4'(1 << k)) : 4'b1111;
      exp_ack = (ph == 9) ? 4'(1 << k) : 4'b0000;
      exp_sel = 4'((1 << k) - 1) | ((ph >= 5) ? 4'(1 << k) : 4'b0000);
      check($sformatf("t4_en_c%0d", c), 32'(o_chan_en), 32'(exp_en));
      check($sformatf("t4_ack_c%0d", c), 32'(o_sel_ack), 32'(exp_ack));
      check($sformatf("t4_sel_c%0d", c), 32'(o_mux_sel), 32'(exp_sel));
      if (ph == 9) i_sel_req = i_sel_req & ~4'(1 << k);
    end
    step(1);
    check("t4_idle", 32'(o_busy), 32'h0);

    // 5: fairness, ch0 re-requests while ch2 keeps requesting
    do_reset();
    i_sel_req    = 4'b0101;
    i_sel_target = 4'b0101;
    step(1);
    check("t5_g0_en", 32'(o_chan_en), 32'hE);
    step(8);
    check("t5_ack0", 32'(o_sel_ack), 32'h1);
    i_sel_req = 4'b0100;
    step(1);
    check("t5_g2_en", 32'(o_chan_en), 32'hB);
    i_sel_req    = 4'b0101;
    i_sel_target = 4'b0100;
    step(8);
    check("t5_ack2", 32'(o_sel_ack), 32'h4);
    check("t5_sel_a", 32'(o_mux_sel), 32'h5);
    step(1);
    check("t5_g0_again_en", 32'(o_chan_en), 32'hE);
    step(8);
    check("t5_ack0_again", 32'(o_sel_ack), 32'h1);
    check("t5_sel_b", 32'(o_mux_sel), 32'h4);
    i_sel_req = 4'b0100;
    step(1);
    check("t5_skip2_ack", 32'(o_sel_ack), 32'h4);
    check("t5_skip2_busy", 32'(o_busy), 32'h0);
    i_sel_req = '0;
    step(1);

    // 6: late target change ignored, withdrawn request never acked
    do_reset();
    i_sel_req    = 4'b0010;
    i_sel_target = 4'b0010;
    step(2);
    i_sel_req    = 4'b0110;
    i_sel_target = 4'b0100;
    step(3);
    check("t6_sel_sampled", 32'(o_mux_sel), 32'h2);
    i_sel_req = 4'b0010;
    step(4);
    check("t6_ack1", 32'(o_sel_ack), 32'h2);
    check("t6_sel_final", 32'(o_mux_sel), 32'h2);
    i_sel_req = '0;
    ack_seen  = '0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      ack_seen = ack_seen | o_sel_ack;
    end
    check("t6_no_ack2", 32'(ack_seen), 32'h0);
    check("t6_en", 32'(o_chan_en), 32'hF);
    check("t6_busy", 32'(o_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
